// File: rtl/divide_radix_if.sv
// Handshake and operand bundle for divide_radix.
// The abort signal exists only when DIVIDE_ABORT_EN is defined.
interface divide_radix_if #(
    parameter int WIDTH = 8
);
    // start is a request accepted only while the divider is idle (busy=0, finish=0);
    // finish is a one-cycle result-valid pulse with no backpressure, results then hold.
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             finish;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
`ifdef DIVIDE_ABORT_EN
    logic             abort;

    modport master (
        output start, dividend, divisor, abort,
        input  busy, finish, quotient, remainder, div_by_zero
    );
    modport slave (
        input  start, dividend, divisor, abort,
        output busy, finish, quotient, remainder, div_by_zero
    );
`else
    modport master (
        output start, dividend, divisor,
        input  busy, finish, quotient, remainder, div_by_zero
    );
    modport slave (
        input  start, dividend, divisor,
        output busy, finish, quotient, remainder, div_by_zero
    );
`endif
endinterface

// File: rtl/divide_radix.sv
// Fixed-latency restoring divider retiring RADIX_BITS quotient bits per cycle.
// Defining DIVIDE_ABORT_EN adds an abort input that cancels a running division.
module divide_radix #(
    parameter int WIDTH      = 8,
    parameter int RADIX_BITS = 1
) (
    input  logic          clk,
    input  logic          rst,
    divide_radix_if.slave bus,
    output logic [1:0]    state_o
);
    localparam int ITER  = WIDTH / RADIX_BITS;
    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER - 1);

    if (WIDTH < 2) begin : g_chk_width
        $error("divide_radix: WIDTH must be at least 2");
    end
    if (RADIX_BITS != 1 && RADIX_BITS != 2 && RADIX_BITS != 4) begin : g_chk_radix
        $error("divide_radix: RADIX_BITS must be 1, 2 or 4");
    end
    if ((WIDTH % RADIX_BITS) != 0) begin : g_chk_div
        $error("divide_radix: WIDTH must be a multiple of RADIX_BITS");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] divisor_q;
    logic [WIDTH-1:0] rem_q, quo_q;
    logic [WIDTH-1:0] rem_d, quo_d;
    logic             dbz_pend_q;
    logic             busy_q, finish_q, dbz_q;
    logic [WIDTH-1:0] quotient_q, remainder_q;

    logic [WIDTH-1:0] acc_rem, acc_quo;
    logic [WIDTH:0]   trial;
    logic [WIDTH+1:0] diff;

    // diff[WIDTH+1] is the borrow of the WIDTH+1 bit trial subtraction.
    always_comb begin
        acc_rem = rem_q;
        acc_quo = quo_q;
        trial   = '0;
        diff    = '0;
        for (int s = 0; s < RADIX_BITS; s++) begin
            trial   = {acc_rem, acc_quo[WIDTH-1]};
            diff    = {1'b0, trial} - {2'b00, divisor_q};
            acc_quo = {acc_quo[WIDTH-2:0], ~diff[WIDTH+1]};
            // A kept difference is always below 2**WIDTH, so its bit WIDTH is zero.
            acc_rem = diff[WIDTH+1] ? trial[WIDTH-1:0] : WIDTH'(diff[WIDTH:0]);
        end
        rem_d = acc_rem;
        quo_d = acc_quo;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            divisor_q   <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dbz_pend_q  <= 1'b0;
            busy_q      <= 1'b0;
            finish_q    <= 1'b0;
            dbz_q       <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    finish_q <= 1'b0;
                    if (bus.start) begin
                        divisor_q  <= bus.divisor;
                        rem_q      <= '0;
                        quo_q      <= bus.dividend;
                        dbz_pend_q <= (bus.divisor == '0);
                        cnt_q      <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= CALC;
                    end
                end
                CALC: begin
`ifdef DIVIDE_ABORT_EN
                    if (bus.abort) begin
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else
`endif
                    begin
                        rem_q <= rem_d;
                        quo_q <= quo_d;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LAST) begin
                            busy_q      <= 1'b0;
                            finish_q    <= 1'b1;
                            quotient_q  <= quo_d;
                            remainder_q <= rem_d;
                            dbz_q       <= dbz_pend_q;
                            state_q     <= DONE;
                        end
                    end
                end
                DONE: begin
                    finish_q <= 1'b0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.finish      = finish_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;
    assign state_o         = state_q;
endmodule

// File: doc/divide_radix.md
Name: divide_radix

Overview:
- Parametrised successor to the team's iterative restoring divider for the RSA datapath (modular reduction, quotient-digit generation).
- Retires RADIX_BITS quotient bits per clock and has a fixed, data-independent latency, so it is safe inside the timing-hardened (secure) modules.
- Adds divide-by-zero reporting, a busy/done handshake, and output holding.
- Sits between the modular-exponentiation controller and its operand registers.

Parameters:
- WIDTH, 8, operand width in bits for dividend, divisor, quotient and remainder. Must be ≥2.
- RADIX_BITS, 1, quotient bits resolved per cycle. Legal values are 1, 2 and 4; WIDTH must be divisible by RADIX_BITS (elaboration error otherwise).
- ITER (localparam), WIDTH/RADIX_BITS, number of compute cycles.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- start  in  1  request pulse; sampled only in IDLE
- dividend  in  WIDTH  numerator, unsigned
- divisor  in  WIDTH  denominator, unsigned
- busy  out  1  high while a division is in progress
- finish  out  1  single-cycle completion pulse
- quotient  out  WIDTH  floor(dividend/divisor)
- remainder  out  WIDTH  dividend mod divisor
- div_by_zero  out  1  divisor was 0 for the result currently presented
- abort  in  1  present only when DIVIDE_ABORT_EN is defined

Behaviour:
- Reset: rst=1 at a clock edge forces state IDLE, iteration counter 0, and busy=0, finish=0, quotient=0, remainder=0, div_by_zero=0.
  - Reset has priority over all other inputs, including mid-computation; the in-flight result is discarded and no finish pulse is produced.
- States: IDLE, CALC, DONE.
- IDLE:
  - start=1 at edge T latches dividend and divisor into internal registers, loads the working accumulator {remainder=0, quotient=dividend}, clears the counter, and moves to CALC.
  - Inputs are not sampled again until the next return to IDLE.
- CALC:
  - Each cycle performs RADIX_BITS chained restoring steps combinationally.
  - Each step: shift the {rem,quo} pair left one bit, trial-subtract the divisor from the top WIDTH+1 bits, keep the difference if it is non-negative, and shift in 1 (else 0).
  - Trial subtraction is WIDTH+1 bits wide so no carry is lost when WIDTH is at its maximum.
  - The counter increments each cycle. After ITER cycles (counter == ITER-1) the state moves to DONE.
- DONE:
  - Lasts one cycle. The quotient, remainder and div_by_zero output registers update at the edge entering DONE, and finish=1 during DONE.
  - The next state is always IDLE; start is ignored while in DONE.
- Latency: start sampled at edge T gives busy=1 for cycles T+1 … T+ITER and finish=1 in cycle T+ITER+1.
  - Latency is identical for every operand value, including divisor 0.
  - There is no early termination on small operands or leading zeros.
- Outputs quotient, remainder and div_by_zero hold their last values until the next DONE; they do not change during a subsequent computation.
- start while busy or in DONE is ignored; there is no queueing.
- Divisor 0:
  - The datapath runs unchanged for ITER cycles (constant time).
  - Natural restoring arithmetic yields quotient = all ones and remainder = dividend; this must be produced without a bypass mux that shortens the timing.
  - div_by_zero=1 in the presented result.
- dividend < divisor gives quotient=0 and remainder=dividend.

Optional Feature:
- DIVIDE_ABORT_EN defined:
  - Adds input abort. abort=1 at an edge in CALC returns the block to IDLE on the next edge.
  - busy drops, no finish pulse is produced, and the output registers keep their previous result.
  - abort in IDLE or DONE has no effect; rst still has priority.
- DIVIDE_ABORT_EN undefined: no abort port, and CALC always runs to completion.

Test Plan:
- WIDTH=8, RADIX_BITS=1: dividend=200, divisor=7, start at edge T → busy high 8 cycles; finish in cycle T+9; quotient=28, remainder=4, div_by_zero=0.
- WIDTH=8, RADIX_BITS=2: dividend=255, divisor=1 and dividend=3, divisor=250 → both finish exactly 5 cycles after start; results (255,0) and (0,3). Confirms constant latency.
- WIDTH=8, divisor=0, dividend=77 → finish at the same cycle count as a non-zero divisor; quotient=255, remainder=77, div_by_zero=1.
- WIDTH=16, RADIX_BITS=4: start pulsed again in cycles T+2 and T+5 with new operands → ignored; a single finish pulse, with the result from the first operands (e.g. 50000/123 → q=406, r=62).
- rst=1 in cycle T+3 mid-CALC → next cycle IDLE, all outputs 0, no finish; a new start then completes normally.
- DIVIDE_ABORT_EN defined, abort at T+2 → busy low at T+3, no finish, outputs equal to the prior result (e.g. 28/4 retained).
